// File: rtl/ahb_vga_writer.sv
// Character-stream to AHB-Lite writer: buffers characters in a small FIFO and
// issues one single NONSEQ write per character to the VGA text data register.
module ahb_vga_writer #(
  parameter logic [31:0] VGA_BASE   = 32'h5000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        HSEL,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  output logic        HREADY,
  input  logic        HREADYOUT,
  output logic        busy,
  output logic [15:0] char_count
);

  localparam int          PW         = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [PW:0]   r_count;
  logic [31:0]   r_hwdata;
  logic [15:0]   r_charCount;
  logic          w_push;
  logic          w_pop;
  logic          w_fifoEmpty;
  logic          w_complete;

  // char_ready comes from the registered occupancy, so a full FIFO never sees a push
  assign char_ready  = (r_count != FULL_COUNT);
  assign w_fifoEmpty = (r_count == '0);
  assign w_push      = char_valid && char_ready;
  assign w_pop       = (r_state == ADDR);
  assign w_complete  = (r_state == DATA) && HREADYOUT;

  assign HREADY     = HREADYOUT;
  assign HWDATA     = r_hwdata;
  assign char_count = r_charCount;
  assign busy       = (r_state != IDLE) || !w_fifoEmpty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= char_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hwdata    <= '0;
      r_charCount <= '0;
    end else begin
      if (w_pop) begin
        r_hwdata <= {24'h0, r_mem[r_rdPtr]};
      end
      if (w_complete) begin
        r_charCount <= r_charCount + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A push on the idle edge starts the address phase immediately
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_push || !w_fifoEmpty) begin
          w_nextState = ADDR;
        end
      end
      ADDR: w_nextState = DATA;
      DATA: begin
        if (HREADYOUT) begin
          w_nextState = (w_fifoEmpty && !w_push) ? IDLE : ADDR;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HADDR  = '0;
    if (r_state == ADDR) begin
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = 1'b1;
      HADDR  = VGA_BASE;
    end
  end

endmodule

// File: tb/tb_ahb_vga_writer.sv
// Directed bench for ahb_vga_writer: a bus monitor pops a scoreboard of pushed
// characters at each completed data phase and checks address/data phases.
module tb_ahb_vga_writer;

  localparam logic [31:0] BASE = 32'h5000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT = 1'b1;
  logic        busy;
  logic [15:0] char_count;

  int         total = 0;
  int         bad = 0;
  logic [7:0] q[$];
  logic       pending = 1'b0;
  int         completions = 0;
  int         addrPhases = 0;
  int         dataCycles = 0;
  int         lastDataCycles = 0;
  int         readyMode = 1;
  int         waitsPerXfer = 0;
  int         waitLeft = 0;

  ahb_vga_writer #(.VGA_BASE(BASE), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .busy(busy), .char_count(char_count)
  );

  always #5 clk = ~clk;

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offers one character for one edge; accepted characters enter the scoreboard
  task applyStimulus(input logic [7:0] d, output logic acc);
    char_valid = 1'b1;
    char_data  = d;
    @(negedge clk);
    acc = char_ready;
    if (acc) q.push_back(d);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
  endtask

  task waitDrain(input int maxCycles);
    int n;
    n = 0;
    while ((q.size() != 0 || pending) && n < maxCycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_in_time", n < maxCycles, 1);
    @(posedge clk);
    #1;
  endtask

  task monitorBus();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending = 1'b0;
        q.delete();
      end else if (pending) begin
        dataCycles++;
        checkOutput("data_hsel", HSEL, 0);
        checkOutput("data_htrans", HTRANS, 0);
        checkOutput("data_hready", HREADY, HREADYOUT);
        checkOutput("data_sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) checkOutput("data_hwdata", HWDATA, {24'h0, q[0]});
        if (HREADYOUT) begin
          if (q.size() != 0) void'(q.pop_front());
          completions++;
          lastDataCycles = dataCycles;
          pending = 1'b0;
        end
      end else if (HSEL) begin
        checkOutput("addr_htrans", HTRANS, 2'b10);
        checkOutput("addr_haddr", HADDR, BASE);
        checkOutput("addr_hwrite", HWRITE, 1);
        addrPhases++;
        pending = 1'b1;
        dataCycles = 0;
      end
    end
  endtask

  task driveReady();
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        0: HREADYOUT = 1'b0;
        2: HREADYOUT = pending ? 1'($urandom_range(0, 1)) : 1'b1;
        3: begin
          if (pending && waitLeft > 0) begin
            HREADYOUT = 1'b0;
            waitLeft--;
          end else begin
            HREADYOUT = 1'b1;
            if (!pending) waitLeft = waitsPerXfer;
          end
        end
        default: HREADYOUT = 1'b1;
      endcase
    end
  endtask

  initial begin
    logic       acc;
    int         c0;
    int         a0;
    int         tries;
    logic [7:0] d;
    logic [5:0] fullPattern;

    fork
      monitorBus();
      driveReady();
    join_none

    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_hsel", HSEL, 0);
    checkOutput("rst_htrans", HTRANS, 2'b00);
    checkOutput("rst_hwrite", HWRITE, 0);
    checkOutput("rst_haddr", HADDR, 0);
    checkOutput("rst_hwdata", HWDATA, 0);
    checkOutput("rst_char_ready", char_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_char_count", char_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single character");
    c0 = completions; a0 = addrPhases;
    applyStimulus(8'h41, acc);
    checkOutput("t1_accept", acc, 1);
    @(negedge clk);
    checkOutput("t1_addr_next_cycle", HSEL, 1);
    waitDrain(50);
    checkOutput("t1_completions", completions - c0, 1);
    checkOutput("t1_addr_phases", addrPhases - a0, 1);
    checkOutput("t1_char_count", char_count, 1);
    checkOutput("t1_busy", busy, 0);
    checkOutput("t1_char_ready", char_ready, 1);

    $display("[TB] wait states");
    readyMode = 3; waitsPerXfer = 3;
    c0 = completions; a0 = addrPhases;
    applyStimulus(8'h5A, acc);
    checkOutput("t2_accept", acc, 1);
    waitDrain(50);
    checkOutput("t2_data_cycles", lastDataCycles, 4);
    checkOutput("t2_completions", completions - c0, 1);
    checkOutput("t2_addr_phases", addrPhases - a0, 1);
    checkOutput("t2_char_count", char_count, 2);

    $display("[TB] full fifo");
    readyMode = 0;
    c0 = completions;
    fullPattern = 6'b011111;
    for (int i = 0; i < 6; i++) begin
      d = 8'hA0 + 8'(i);
      applyStimulus(d, acc);
      checkOutput($sformatf("t3_accept_%0d", i), acc, fullPattern[i]);
    end
    checkOutput("t3_char_ready_low", char_ready, 0);
    checkOutput("t3_busy", busy, 1);
    checkOutput("t3_sb_depth", q.size(), 5);
    readyMode = 1;
    waitDrain(100);
    checkOutput("t3_completions", completions - c0, 5);
    checkOutput("t3_char_count", char_count, 7);
    checkOutput("t3_char_ready", char_ready, 1);

    $display("[TB] burst order with random ready");
    readyMode = 2;
    c0 = completions;
    for (int i = 0; i < 8; i++) begin
      d = 8'h10 + 8'(i);
      tries = 0;
      do begin
        applyStimulus(d, acc);
        tries++;
      end while (!acc && tries < 40);
      checkOutput($sformatf("t4_offer_%0d", i), acc, 1);
    end
    waitDrain(400);
    readyMode = 1;
    checkOutput("t4_completions", completions - c0, 8);
    checkOutput("t4_char_count", char_count, 15);
    checkOutput("t4_busy", busy, 0);

    $display("[TB] char_count wrap");
    force dut.r_charCount = 16'hFFFF;
    #1;
    release dut.r_charCount;
    @(posedge clk);
    #1;
    checkOutput("t5_preset", char_count, 16'hFFFF);
    applyStimulus(8'h55, acc);
    checkOutput("t5_accept", acc, 1);
    waitDrain(50);
    checkOutput("t5_char_count_wrap", char_count, 0);

    $display("[TB] reset during data phase");
    readyMode = 0;
    c0 = completions; a0 = addrPhases;
    applyStimulus(8'h77, acc);
    checkOutput("t6_accept", acc, 1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t6_in_data", pending, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_hsel", HSEL, 0);
    checkOutput("t6_htrans", HTRANS, 2'b00);
    checkOutput("t6_hwrite", HWRITE, 0);
    checkOutput("t6_haddr", HADDR, 0);
    checkOutput("t6_hwdata", HWDATA, 0);
    checkOutput("t6_char_ready", char_ready, 1);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_char_count", char_count, 0);
    readyMode = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t6_no_completion", completions - c0, 0);
    checkOutput("t6_no_new_addr", addrPhases - a0, 1);
    checkOutput("t6_count_after", char_count, 0);
    checkOutput("t6_busy_after", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_vga_writer.md
AHB_VGA_WRITER -- requirements
Module: ahb_vga_writer

Interface
REQ-001 The block SHALL have parameter VGA_BASE, default 32'h5000_0000, giving the AHB address of the VGA text data register.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the character FIFO depth (power of 2, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port char_valid, input, 1 bit: a character is offered.
REQ-006 The block SHALL have port char_data, input, 8 bits: the offered character.
REQ-007 The block SHALL have port char_ready, output, 1 bit: high when the FIFO is not full.
REQ-008 The block SHALL have port HSEL, output, 1 bit: VGA slave select.
REQ-009 The block SHALL have port HADDR, output, 32 bits: address phase address.
REQ-010 The block SHALL have port HTRANS, output, 2 bits: 2'b10 (NONSEQ) or 2'b00 (IDLE) only.
REQ-011 The block SHALL have port HWRITE, output, 1 bit: transfer direction.
REQ-012 The block SHALL have port HWDATA, output, 32 bits: data phase write data.
REQ-013 The block SHALL have port HREADY, output, 1 bit: bus ready to the slave.
REQ-014 The block SHALL have port HREADYOUT, input, 1 bit: slave ready.
REQ-015 The block SHALL have port busy, output, 1 bit: FIFO non-empty or a transfer in flight.
REQ-016 The block SHALL have port char_count, output, 16 bits: number of completed writes.

Function
REQ-017 An offer SHALL be accepted when char_valid and char_ready are both high on a rising edge; char_data is pushed into the FIFO.
REQ-018 An offer with char_ready low SHALL be ignored, with no FIFO change.
REQ-019 A push and a pop in the same cycle on a full FIFO SHALL NOT be possible, because char_ready is registered from the occupancy at the start of the cycle.
REQ-020 A push and a pop in the same cycle on a non-full FIFO SHALL both take effect, leaving occupancy unchanged.
REQ-021 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 The FSM SHALL have three states: IDLE, ADDR and DATA.
REQ-023 IDLE: HTRANS=IDLE and HSEL=0; move to ADDR when the FIFO is non-empty.
REQ-024 ADDR (one cycle): HSEL=1, HTRANS=NONSEQ, HWRITE=1, HADDR=VGA_BASE; the FIFO head is popped into the data-phase register.
REQ-025 ADDR SHALL always move to DATA on the next edge, because HREADY=1 throughout ADDR.
REQ-026 DATA: HTRANS=IDLE, HSEL=0, HWDATA={24'h0, popped char}.
REQ-027 DATA SHALL hold HWDATA stable while HREADYOUT=0.
REQ-028 DATA SHALL complete on the edge where HREADYOUT=1.
REQ-029 On completion, DATA SHALL go to ADDR if the FIFO is non-empty, else to IDLE; no back-to-back pipelining of address and data phases.
REQ-030 HREADY SHALL equal HREADYOUT combinationally.
REQ-031 char_count SHALL increment by 1 on each completion and wrap from 16'hFFFF to 0.
REQ-032 busy SHALL be high when the state is not IDLE or the FIFO is non-empty.
REQ-033 Minimum latency from push into an empty FIFO while IDLE: ADDR one cycle after the push edge, DATA the cycle after that, so 3 cycles per character with zero wait states.
REQ-034 Outside DATA, HWDATA SHALL hold its last value.

Reset
REQ-035 When rst_n is low, the following SHALL be forced asynchronously: state=IDLE, FIFO empty, pointers 0, char_count=0, HWDATA=0.
REQ-036 The reset-derived outputs SHALL therefore be: HSEL=0, HTRANS=2'b00, HWRITE=0, HADDR=0, char_ready=1, busy=0.
REQ-037 Reset asserted mid-transfer (ADDR or DATA) SHALL abandon the transfer, discard FIFO contents, and not increment char_count.

Verification
REQ-038 Single char: push 8'h41 while IDLE with HREADYOUT=1 -> exactly one NONSEQ write to 32'h5000_0000, HWDATA=32'h41 in the next cycle, char_count=1, busy=0 after completion.
REQ-039 Wait states: HREADYOUT low for 3 DATA cycles -> HWDATA stable for 4 cycles, no new NONSEQ issued, a single increment.
REQ-040 Full FIFO: 6 consecutive offers with HREADYOUT held 0 -> char_ready falls after the FIFO fills (4 in FIFO, 1 in flight); excess offers are dropped; the writes drain in order.
REQ-041 Burst order: push 8'h10..8'h17 with random HREADYOUT -> the HWDATA sequence equals the push order, char_count=8.
REQ-042 Wrap: preload char_count to 16'hFFFF via 65535 writes, or force it in simulation, then one write -> char_count=0.
REQ-043 Reset during DATA with HREADYOUT=0 -> outputs at reset values immediately, with no completion counted.
